sc_stream_decoder: RTL

Stochastic-to-binary converter for the scaled SFFT datapath. It is the receive end of the Sobol-driven bitstream generator: it counts the 1s in a unipolar bitstream over a fixed window of 2^BITWIDTH enabled cycles. It then presents the count as a BITWIDTH-bit binary value on a valid/ready output handshake.

---
 rtl/sc_stream_decoder_pkg.sv | 22 ++
 rtl/sc_window_counter.sv | 30 +++
 rtl/sc_stream_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/sc_stream_decoder_pkg.sv
// Shared types and constants for the stochastic bitstream decoder.
// FSM state codes and window sizing helpers.
package sc_stream_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned DEF_BITWIDTH = 8;
  localparam int unsigned DEF_WINDOW   = 1 << DEF_BITWIDTH;

  function automatic int unsigned window_len(input int unsigned bw);
    return 1 << bw;
  endfunction

  function automatic int unsigned sat_max(input int unsigned bw);
    return (1 << bw) - 1;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Enabled bit-cycle index within one decode window.
// Pulses tc_o on the enabled cycle that closes the window.
module sc_window_counter #(
  parameter int BITWIDTH = 8
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  import sc_stream_decoder_pkg::*;

  logic [BITWIDTH-1:0] tick_q;
  logic [BITWIDTH-1:0] tick_d;

  assign tick_d = tick_q + 1'b1;
  assign tc_o   = en_i && (tick_q == {BITWIDTH{1'b1}});

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tick_q <= '0;
    end else if (clr_i) begin
      tick_q <= '0;
    end else if (en_i) begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts 1s of a unipolar bitstream over 2^BITWIDTH enabled cycles
// and returns the saturated count on a valid/ready handshake.
module sc_stream_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iBit,
  output logic                oBusy,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oSat
);
  import sc_stream_decoder_pkg::*;

  localparam int unsigned WINDOW = window_len(BITWIDTH);
  localparam int unsigned SATMAX = sat_max(BITWIDTH);
  localparam logic [BITWIDTH:0] WIN = (BITWIDTH+1)'(WINDOW);
  localparam logic [BITWIDTH-1:0] MAXV = BITWIDTH'(SATMAX);

  state_e            state_q;
  logic [BITWIDTH:0] ones_q;
  logic [BITWIDTH:0] ones_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              tc;
  logic              hs_start;

  assign ones_d   = ones_q + (BITWIDTH+1)'(iBit);
  assign hs_start = (state_q == HOLD) && iReady && iStart;
  assign cnt_clr  = iClr || hs_start ||
                    ((state_q == IDLE) && iStart);
  assign cnt_en   = !iClr && (state_q == ACCUM) && iEn;

  sc_window_counter #(
    .BITWIDTH(BITWIDTH)
  ) u_win (
    .iClk  (iClk),
    .iRstN (iRstN),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      ones_q  <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oSat    <= 1'b0;
    end else if (iClr) begin
      state_q <= IDLE;
      ones_q  <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oSat    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          oValid <= 1'b0;
          if (iStart) begin
            ones_q  <= '0;
            oBusy   <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (iEn) begin
            ones_q <= ones_d;
            // Terminal bit is already folded into ones_d.
            if (tc) begin
              oSat    <= (ones_d == WIN);
              oData   <= (ones_d == WIN) ? MAXV
                                         : ones_d[BITWIDTH-1:0];
              oValid  <= 1'b1;
              oBusy   <= 1'b0;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (iReady) begin
            oValid <= 1'b0;
            if (iStart) begin
              ones_q  <= '0;
              oBusy   <= 1'b1;
              state_q <= ACCUM;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          oBusy   <= 1'b0;
          oValid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
